// File: rtl/intpol2_d4_ctrl_fsm.sv
// Sequencing FSM for the intpol2_D4 quadratic interpolator: clear, coefficient preload,
// FIFO fetch, pipeline wait, PHASES output writes per input sample, accumulate and done.
module intpol2_d4_ctrl_fsm #(
  parameter int PHASES   = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        mode,
  input  logic                        Empty,
  input  logic                        Afull,
  input  logic                        comp_addr,
  input  logic                        comp_cnt,
  output logic                        busy,
  output logic                        clear,
  output logic                        en_M_addr,
  output logic                        Read_Enable,
  output logic                        Write_Enable,
  output logic                        en_sum,
  output logic                        done,
  output logic [$clog2(PHASES)-1:0]   phase
);

  localparam int PW = $clog2(PHASES);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_PRELOAD, S_FETCH, S_WAIT, S_CALC, S_NEXT, S_DONE, S_ABORT
  } state_t;

  state_t          r_state, w_nxt;
  logic [3:0]      r_wcnt, w_wcnt_nxt;
  logic [PW-1:0]   r_phase, w_phase_nxt;
  logic            r_busy, r_clear, r_en_m, r_en_sum, r_done;
  logic            w_rd, w_wr;

  // Mealy strobes are squashed by abort so nothing is popped or pushed in that cycle.
  assign w_rd = (r_state == S_FETCH) & ~Empty & ~abort;
  assign w_wr = (r_state == S_CALC)  & ~Afull & ~abort;

  always_comb begin
    w_nxt       = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_phase_nxt = r_phase;
    case (r_state)
      S_IDLE:    if (start) w_nxt = S_CLR;
      S_CLR: begin
        w_phase_nxt = '0;
        w_nxt       = mode ? S_FETCH : S_PRELOAD;
      end
      S_PRELOAD: if (comp_addr) w_nxt = S_FETCH;
      S_FETCH: begin
        if (!Empty) begin
          w_wcnt_nxt = 4'(PIPE_LAT);
          w_nxt      = (PIPE_LAT == 0) ? S_CALC : S_WAIT;
        end
      end
      S_WAIT: begin
        w_wcnt_nxt = r_wcnt - 4'd1;
        if (r_wcnt <= 4'd1) w_nxt = S_CALC;
      end
      S_CALC: begin
        if (!Afull) begin
          if (r_phase == PW'(PHASES - 1)) begin
            w_phase_nxt = '0;
            w_nxt       = S_NEXT;
          end else begin
            w_phase_nxt = r_phase + 1'b1;
          end
        end
      end
      S_NEXT:    w_nxt = comp_cnt ? S_DONE : S_FETCH;
      S_DONE:    w_nxt = S_IDLE;
      S_ABORT:   w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_nxt       = S_ABORT;
      w_phase_nxt = '0;
      w_wcnt_nxt  = '0;
    end
  end

  // Moore outputs are registered from the next-state decode, so they line up with r_state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_wcnt   <= '0;
      r_phase  <= '0;
      r_busy   <= 1'b0;
      r_clear  <= 1'b0;
      r_en_m   <= 1'b0;
      r_en_sum <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_phase  <= w_phase_nxt;
      r_busy   <= (w_nxt != S_IDLE);
      r_clear  <= (w_nxt == S_CLR) || (w_nxt == S_ABORT);
      r_en_m   <= (w_nxt == S_PRELOAD);
      r_en_sum <= (w_nxt == S_NEXT);
      r_done   <= (w_nxt == S_DONE);
    end
  end

  assign busy         = r_busy;
  assign clear        = r_clear;
  assign en_M_addr    = r_en_m;
  assign en_sum       = r_en_sum;
  assign done         = r_done;
  assign phase        = r_phase;
  assign Read_Enable  = w_rd;
  assign Write_Enable = w_wr;

endmodule
